// File: rtl/clique_scan_ctrl_if.sv
// Row-load / start / result bundle between the graph loader and clique_scan_ctrl.
interface clique_scan_ctrl_if #(parameter int N = 3);
  logic [N-1:0] row_data;
  logic         row_valid;
  logic         row_ready;
  logic         start;
  logic         busy;
  logic         done;
  logic [N:0]   clique_count;
  logic [3:0]   max_clique;

  modport master (
    output row_data, row_valid, start,
    input  row_ready, busy, done, clique_count, max_clique
  );

  modport slave (
    input  row_data, row_valid, start,
    output row_ready, busy, done, clique_count, max_clique
  );
endinterface

// File: rtl/clique_scan_ctrl.sv
// Loads an N-vertex adjacency matrix row by row, then walks every non-empty
// subset at one per clock, counting cliques and tracking the largest one.

module clique_scan_vtx #(
  parameter int N   = 3,
  parameter int IDX = 0
) (
  input  logic [N-1:0] subset,
  input  logic [N-1:0] row,
  input  logic [N-1:0] col,
  output logic         conflict
);
  localparam logic [N-1:0] SELF = {{(N-1){1'b0}}, 1'b1} << IDX;

  // An edge needs both directions; the diagonal is masked out.
  assign conflict = subset[IDX] & (|(subset & ~(row & col) & ~SELF));
endmodule

module clique_scan_ctrl #(
  parameter int N        = 3,
  parameter int MIN_SIZE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  clique_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [N-1:0] S_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   C_ONE = {{N{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [3:0]            row_ptr;
  logic [N-1:0][N-1:0]   adj;
  logic [N-1:0][N-1:0]   adj_t;
  logic [N-1:0]          s;
  logic [N:0]            count;
  logic [3:0]            max_sz;
  logic [N-1:0]          conflict;
  logic [3:0]            pop;
  logic                  loaded, take_row, take_start, last, is_clique;

  assign loaded     = (row_ptr == 4'(N));
  assign take_row   = (state == IDLE) && bus.row_valid && !loaded;
  assign take_start = (state == IDLE) && bus.start && loaded;
  assign last       = &s;
  assign is_clique  = ~|conflict;

  always_comb begin
    adj_t = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        adj_t[i][j] = adj[j][i];
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++)
      pop = pop + 4'(s[i]);
  end

  for (genvar i = 0; i < N; i++) begin : g_vtx
    clique_scan_vtx #(.N(N), .IDX(i)) u_vtx (
      .subset   (s),
      .row      (adj[i]),
      .col      (adj_t[i]),
      .conflict (conflict[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.row_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.row_ready = !loaded;
        if (take_start) state_nxt = SCAN;
      end
      SCAN: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_ptr <= '0;
      adj     <= '0;
      s       <= '0;
      count   <= '0;
      max_sz  <= '0;
    end else begin
      if (take_row) begin
        for (int i = 0; i < N; i++)
          if (row_ptr == 4'(i)) adj[i] <= bus.row_data;
        row_ptr <= row_ptr + 4'd1;
      end
      if (take_start) begin
        count  <= '0;
        max_sz <= '0;
        s      <= S_ONE;
      end
      if (state == SCAN) begin
        s <= s + S_ONE;
        if (is_clique) begin
          if (pop > max_sz)          max_sz <= pop;
          if (pop >= 4'(MIN_SIZE))   count  <= count + C_ONE;
        end
      end
      // A finished scan consumes the matrix; the next start needs a fresh load.
      if (state == DONE) row_ptr <= '0;
    end
  end

  assign bus.clique_count = count;
  assign bus.max_clique   = max_sz;
endmodule
